scope_vga_render: RTL and testbench
===================================

SCOPE_VGA_RENDER -- requirements
Module: scope_vga_render

Interface
Parameters (name, default, meaning):
REQ-001 CHANNELS, 2, number of trace channels, range 1..8.
REQ-002 SAMPLE_W, 8, sample width in bits; a trace spans 2^SAMPLE_W rows.
REQ-003 H_ACTIVE, 1280 / H_FP, 48 / H_SYNC, 112 / H_BP, 248, horizontal timing in pixel clocks.
REQ-004 V_ACTIVE, 1024 / V_FP, 1 / V_SYNC, 3 / V_BP, 38, vertical timing in lines.
REQ-005 PLOT_TOP, 256, first active row of the plot window.
Ports (name, direction, width, meaning):
REQ-006 clock  in  1  pixel clock; all logic on the rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset; one clock, sampled on the rising edge.
REQ-008 wr_valid  in  1  sample write request.
REQ-009 wr_ready  out  1  sample write accepted when high with wr_valid.
REQ-010 wr_channel  in  3  target channel.
REQ-011 wr_index  in  clog2(H_ACTIVE)  column index.
REQ-012 wr_data  in  SAMPLE_W  sample value.
REQ-013 frame_start  out  1  one-cycle pulse at the first active pixel of each frame.
REQ-014 vga_hsync, vga_vsync  out  1 each  active-high syncs.
REQ-015 R, G, B  out  8 each  pixel colour.

Function
REQ-016 Free-running counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1; v_cnt advances when h_cnt wraps; both wrap to 0.
REQ-017 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; sync high when count in [ACTIVE+FP, ACTIVE+FP+SYNC).
REQ-018 Per channel, one H_ACTIVE x SAMPLE_W buffer; write at (wr_channel, wr_index) on wr_valid&&wr_ready.
REQ-019 wr_ready SHALL be high only while v_cnt>=V_ACTIVE (vertical blanking), so no frame displays a mid-update buffer.
REQ-020 Writes with wr_channel>=CHANNELS or wr_index>=H_ACTIVE are accepted (wr_ready honoured) and discarded.
REQ-021 Column h_cnt of channel c lights when v_cnt == PLOT_TOP + (2^SAMPLE_W-1 - sample); sample 0 is the bottom row.
REQ-022 Colour palette by channel mod 4: 0 yellow (FF,FF,00), 1 cyan (00,FF,FF), 2 magenta (FF,00,FF), 3 green (00,FF,00).
REQ-023 Overlapping traces: lowest channel number wins.
REQ-024 Non-trace active pixels black; all blanking pixels R=G=B=0.
REQ-025 Fixed pipeline latency 2 clocks: RGB, vga_hsync, vga_vsync and frame_start all delayed 2 clocks from the counter state producing them, so they stay aligned.
REQ-026 frame_start asserts for exactly one clock per frame, aligned with pixel (0,0) on RGB.

Reset
REQ-027 While reset_n low at a clock edge: h_cnt=v_cnt=0, pipeline cleared, vga_hsync=vga_vsync=0, R=G=B=0, frame_start=0, wr_ready=0.
REQ-028 Sample buffers SHALL NOT be cleared by reset; contents undefined until written.
REQ-029 Reset mid-frame: next frame restarts at (0,0) on the first clock after release, with frame_start 2 clocks later.

Configuration
REQ-030 Macro SCOPE_GRID_EN: when defined, active pixels outside any trace with h_cnt mod 32==0 or (v_cnt-PLOT_TOP) mod 32==0 inside the plot window show grey (40,40,40); traces override grid.
REQ-031 Without SCOPE_GRID_EN: no grid logic; non-trace active pixels black.

Verification
REQ-032 Timing: H=8/2/2/2, V=4/1/1/1 (small params) after reset -> hsync high for h_cnt 10..11, period 14; vsync high lines 5, period 7 lines; frame_start every 98 clocks.
REQ-033 Handshake: wr_valid held during active video -> wr_ready=0, no write; at v_cnt=V_ACTIVE wr_ready=1 and write completes same clock.
REQ-034 Trace: SAMPLE_W=2, PLOT_TOP=0, ch0 col3=0, ch1 col3=3 -> pixel (3,3) yellow, pixel (3,0) cyan, 2 clocks after counters reach them.
REQ-035 Priority: ch0 and ch1 both col5=2 -> pixel (5,1) yellow only.
REQ-036 Out-of-range: wr_channel=7 with CHANNELS=2 -> accepted, no visible change.
REQ-037 Reset mid-frame at v_cnt=2 -> outputs zero during reset, frame_start pulse 2 clocks after release; with SCOPE_GRID_EN, pixel (0,0) grey.

Source files
------------

// File: rtl/scope_vga_render.sv
// scope_vga_render: draws per-channel sample traces onto a VGA raster.
// A trace sample picks the lit row in its column; sample 0 is the bottom row of the plot.
// Optional grey grid overlay behind the traces: define SCOPE_GRID_EN.
module scope_vga_render #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter int unsigned PLOT_TOP = 256
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [2:0]                  wr_channel,
    input  logic [$clog2(H_ACTIVE)-1:0] wr_index,
    input  logic [SAMPLE_W-1:0]         wr_data,
    output logic                        frame_start,
    output logic                        vga_hsync,
    output logic                        vga_vsync,
    output logic [7:0]                  R,
    output logic [7:0]                  G,
    output logic [7:0]                  B
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned IDX_W   = $clog2(H_ACTIVE);
    localparam int unsigned ROWS    = 2 ** SAMPLE_W;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    // raster counters and write handshake
    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           wr_ready_q, wr_ready_d;

    // sample buffers (never reset)
    logic [SAMPLE_W-1:0] mem [CHANNELS][H_ACTIVE];
    logic                mem_we_c;
    logic                idx_ok_c;
    logic [IDX_W-1:0]    rd_col_c;

    // stage 1: raster flags plus buffer read for the current column
    logic                act_s1_q, act_s1_d;
    logic                hs_s1_q, hs_s1_d;
    logic                vs_s1_q, vs_s1_d;
    logic                fs_s1_q, fs_s1_d;
    logic                win_s1_q, win_s1_d;
    logic [SAMPLE_W-1:0] row_s1_q, row_s1_d;
    logic [SAMPLE_W-1:0] samp_s1_q [CHANNELS];
    logic [SAMPLE_W-1:0] samp_s1_d [CHANNELS];
`ifdef SCOPE_GRID_EN
    logic                grid_s1_q, grid_s1_d;
`endif

    // stage 2: registered pixel outputs
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;

    function automatic logic [23:0] palette(input logic [1:0] sel);
        case (sel)
            2'd0:    return 24'hFFFF00;
            2'd1:    return 24'h00FFFF;
            2'd2:    return 24'hFF00FF;
            default: return 24'h00FF00;
        endcase
    endfunction

    // Column indices past H_ACTIVE are only possible when H_ACTIVE is not a power of two.
    if (H_ACTIVE == 2 ** IDX_W) begin : g_idx_full
        assign idx_ok_c = 1'b1;
    end else begin : g_idx_part
        assign idx_ok_c = (32'(wr_index) < H_ACTIVE);
    end

    // Counter advance; wr_ready tracks vertical blanking of the next counter state.
    always_comb begin
        h_cnt_d = h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            if (32'(v_cnt_q) == V_TOTAL - 1) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + V_W'(1);
            end
        end
        wr_ready_d = (32'(v_cnt_d) >= V_ACTIVE);
        mem_we_c   = wr_valid && wr_ready_q && idx_ok_c;
    end

    // Sample buffer write; out-of-range channels match no buffer and are dropped.
    always_ff @(posedge clock) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (mem_we_c && (wr_channel == 3'(c))) begin
                mem[c][wr_index] <= wr_data;
            end
        end
    end

    // Stage 1 next state: region/sync decode and column read.
    always_comb begin
        act_s1_d = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
        hs_s1_d  = (32'(h_cnt_q) >= HS_BEG) && (32'(h_cnt_q) < HS_END);
        vs_s1_d  = (32'(v_cnt_q) >= VS_BEG) && (32'(v_cnt_q) < VS_END);
        fs_s1_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
        // rows above PLOT_TOP wrap to large values and fall outside the window
        win_s1_d = ((32'(v_cnt_q) - PLOT_TOP) < ROWS);
        row_s1_d = SAMPLE_W'(32'(v_cnt_q) - PLOT_TOP);
        rd_col_c = (32'(h_cnt_q) < H_ACTIVE) ? h_cnt_q[IDX_W-1:0] : '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            samp_s1_d[c] = mem[c][rd_col_c];
        end
`ifdef SCOPE_GRID_EN
        grid_s1_d = ((32'(h_cnt_q) & 32'd31) == 32'd0) ||
                    (((32'(v_cnt_q) - PLOT_TOP) & 32'd31) == 32'd0);
`endif
    end

    // Stage 2 next state: colour select, lowest channel drawn last so it wins.
    always_comb begin
        hs_d  = hs_s1_q;
        vs_d  = vs_s1_q;
        fs_d  = fs_s1_q;
        rgb_d = '0;
        if (act_s1_q && win_s1_q) begin
`ifdef SCOPE_GRID_EN
            if (grid_s1_q) begin
                rgb_d = 24'h404040;
            end
`endif
            for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
                // row from top is (ROWS-1 - sample), i.e. the bitwise inverse
                if (row_s1_q == ~samp_s1_q[c]) begin
                    rgb_d = palette(2'(c));
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            wr_ready_q <= 1'b0;
            act_s1_q   <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            fs_s1_q    <= 1'b0;
            win_s1_q   <= 1'b0;
            row_s1_q   <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                samp_s1_q[c] <= '0;
            end
`ifdef SCOPE_GRID_EN
            grid_s1_q  <= 1'b0;
`endif
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            wr_ready_q <= wr_ready_d;
            act_s1_q   <= act_s1_d;
            hs_s1_q    <= hs_s1_d;
            vs_s1_q    <= vs_s1_d;
            fs_s1_q    <= fs_s1_d;
            win_s1_q   <= win_s1_d;
            row_s1_q   <= row_s1_d;
            samp_s1_q  <= samp_s1_d;
`ifdef SCOPE_GRID_EN
            grid_s1_q  <= grid_s1_d;
`endif
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign frame_start = fs_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign R           = rgb_q[23:16];
    assign G           = rgb_q[15:8];
    assign B           = rgb_q[7:0];

endmodule

// File: tb/tb_scope_vga_render.sv
// tb_scope_vga_render: small-raster bench with a frame-level reference model.
module tb_scope_vga_render;
    localparam int CH   = 2;
    localparam int SW   = 2;
    localparam int HA   = 8;
    localparam int HF   = 2;
    localparam int HS   = 2;
    localparam int HB   = 2;
    localparam int VA   = 4;
    localparam int VF   = 1;
    localparam int VS   = 1;
    localparam int VB   = 1;
    localparam int PT   = 0;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int ROWS = 1 << SW;
`ifdef SCOPE_GRID_EN
    localparam logic [23:0] ORIGIN_RGB = 24'h404040;
`else
    localparam logic [23:0] ORIGIN_RGB = 24'h000000;
`endif

    logic       clock;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_channel;
    logic [2:0] wr_index;
    logic [1:0] wr_data;
    logic       frame_start;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    scope_vga_render #(
        .CHANNELS(CH), .SAMPLE_W(SW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PLOT_TOP(PT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
        .wr_index(wr_index), .wr_data(wr_data),
        .frame_start(frame_start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .R(R), .G(G), .B(B)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
        bit          known;
        int          h;
        int          v;
    } px_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   hm = 0;
    int   vm = 0;
    int   mem_m [8][8];
    px_t  p1;
    px_t  p2;
    logic exp_ready = 1'b0;

    function automatic logic [23:0] pal(input int c);
        case (c % 4)
            0:       return 24'hFFFF00;
            1:       return 24'h00FFFF;
            2:       return 24'hFF00FF;
            default: return 24'h00FF00;
        endcase
    endfunction

    function automatic px_t blank_px();
        px_t e;
        e.hs = 1'b0; e.vs = 1'b0; e.fs = 1'b0; e.rgb = 24'h0;
        e.known = 1'b1; e.h = -1; e.v = -1;
        return e;
    endfunction

    // What the screen must show for raster position (h,v) given current buffers.
    function automatic px_t expect_px(input int h, input int v);
        px_t e;
        e.hs = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs = (v >= VA + VF) && (v < VA + VF + VS);
        e.fs = (h == 0) && (v == 0);
        e.rgb = 24'h0; e.known = 1'b1; e.h = h; e.v = v;
        if (h < HA && v < VA) begin
`ifdef SCOPE_GRID_EN
            if (v >= PT && v < PT + ROWS && (h % 32 == 0 || (v - PT) % 32 == 0)) e.rgb = 24'h404040;
`endif
            for (int c = CH - 1; c >= 0; c--) begin
                if (mem_m[c][h] < 0) e.known = 1'b0;
                else if (v == PT + ROWS - 1 - mem_m[c][h]) e.rgb = pal(c);
            end
        end
        return e;
    endfunction

    // Advance the reference by one clock edge; outputs appear two edges after their raster state.
    task automatic model_edge();
        if (!reset_n) begin
            hm = 0; vm = 0; p1 = blank_px(); p2 = blank_px();
        end else begin
            p2 = p1;
            p1 = expect_px(hm, vm);
            if (wr_valid && vm >= VA && int'(wr_index) < HA && int'(wr_channel) < CH)
                mem_m[wr_channel][wr_index] = int'(wr_data);
            hm++;
            if (hm == HT) begin
                hm = 0; vm++;
                if (vm == VT) vm = 0;
            end
        end
        exp_ready = (vm >= VA);
    endtask

    task automatic tick(input logic rst, input logic vld, input logic [2:0] ch,
                        input logic [2:0] idx, input logic [1:0] dat);
        @(negedge clock);
        reset_n = rst; wr_valid = vld; wr_channel = ch; wr_index = idx; wr_data = dat;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 3'd0, 3'd0, 2'd0);
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hm == h && vm == v) && n < 200) begin idle(); n++; end
        if (!(hm == h && vm == v)) begin
            n_checks++;
            $display("FAIL run_to timeout: at (%0d,%0d) want (%0d,%0d)", hm, vm, h, v);
        end
    endtask

    task automatic run_to_vblank();
        int n = 0;
        while (vm < VA && n < 200) begin idle(); n++; end
        if (vm < VA) begin
            n_checks++;
            $display("FAIL vblank timeout: line %0d", vm);
        end
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [2:0] idx, input logic [1:0] dat);
        run_to_vblank();
        tick(1'b1, 1'b1, ch, idx, dat);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 3'd0, 3'd1, 2'd2);
            n_checks++;
            if ({vga_hsync, vga_vsync, frame_start, wr_ready, R, G, B} !== 28'h0)
                $display("FAIL reset_outputs: got %h want 0", {vga_hsync, vga_vsync, frame_start, wr_ready, R, G, B});
            else n_pass++;
        end
    endtask

    // Sync/frame timing straight from the raster arithmetic, counted from reset release.
    task automatic test_timing();
        for (int t = 1; t <= 200; t++) begin
            int  s;
            logic ehs, evs, efs;
            idle();
            s   = t - 2;
            ehs = (s >= 0) && ((s % HT) >= 10) && ((s % HT) < 12);
            evs = (s >= 0) && (((s / HT) % VT) == 5);
            efs = (s >= 0) && ((s % 98) == 0);
            n_checks++;
            if ({vga_hsync, vga_vsync, frame_start} !== {ehs, evs, efs})
                $display("FAIL timing t=%0d: got hs/vs/fs %b want %b", t, {vga_hsync, vga_vsync, frame_start}, {ehs, evs, efs});
            else n_pass++;
        end
    endtask

    task automatic init_buffers();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < HA; i++)
                do_write(3'(c), 3'(i), 2'($urandom_range(3)));
        do_write(3'd0, 3'd0, 2'd1);
        do_write(3'd1, 3'd0, 2'd1);
        do_write(3'd1, 3'd1, 2'd1);
    endtask

    task automatic test_handshake();
        run_to(0, 0);
        for (int n = 0; n < 100; n++) begin
            tick(1'b1, 1'b1, 3'd0, 3'd1, 2'd0);
            if (vm >= VA) break;
            n_checks++;
            if (wr_ready !== 1'b0) $display("FAIL ready_in_active: got %b want 0 at line %0d", wr_ready, vm);
            else n_pass++;
        end
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL ready_at_vblank: got %b want 1", wr_ready);
        else n_pass++;
        tick(1'b1, 1'b1, 3'd0, 3'd1, 2'd3);
        for (int n = 0; n < HT * VT; n++) begin
            idle();
            if (p2.h == 1 && p2.v == 0) begin
                n_checks++;
                if ({R, G, B} !== 24'hFFFF00) $display("FAIL handshake_write (1,0): got %h want ffff00", {R, G, B});
                else n_pass++;
            end
            if (p2.h == 1 && p2.v == 3) begin
                n_checks++;
                if ({R, G, B} !== 24'h000000) $display("FAIL handshake_nowrite (1,3): got %h want 000000", {R, G, B});
                else n_pass++;
            end
        end
    endtask

    task automatic test_trace();
        do_write(3'd0, 3'd3, 2'd0);
        do_write(3'd1, 3'd3, 2'd3);
        for (int n = 0; n < HT * VT; n++) begin
            idle();
            if (p2.h == 3 && p2.v == 3) begin
                n_checks++;
                if ({R, G, B} !== 24'hFFFF00) $display("FAIL trace_ch0 (3,3): got %h want ffff00", {R, G, B});
                else n_pass++;
            end
            if (p2.h == 3 && p2.v == 0) begin
                n_checks++;
                if ({R, G, B} !== 24'h00FFFF) $display("FAIL trace_ch1 (3,0): got %h want 00ffff", {R, G, B});
                else n_pass++;
            end
        end
    endtask

    task automatic test_priority();
        do_write(3'd0, 3'd5, 2'd2);
        do_write(3'd1, 3'd5, 2'd2);
        for (int n = 0; n < HT * VT; n++) begin
            idle();
            if (p2.h == 5 && p2.v == 1) begin
                n_checks++;
                if ({R, G, B} !== 24'hFFFF00) $display("FAIL priority (5,1): got %h want ffff00", {R, G, B});
                else n_pass++;
            end
        end
    endtask

    task automatic test_out_of_range();
        do_write(3'd0, 3'd6, 2'd2);
        do_write(3'd1, 3'd6, 2'd1);
        run_to_vblank();
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL oor_ready: got %b want 1", wr_ready);
        else n_pass++;
        tick(1'b1, 1'b1, 3'd7, 3'd6, 2'd0);
        tick(1'b1, 1'b1, 3'd5, 3'd6, 2'd0);
        for (int n = 0; n < HT * VT; n++) begin
            idle();
            if (p2.h == 6 && p2.v == 3) begin
                n_checks++;
                if ({R, G, B} !== 24'h000000) $display("FAIL oor_discard (6,3): got %h want 000000", {R, G, B});
                else n_pass++;
            end
            if (p2.known) begin
                n_checks++;
                if ({R, G, B} !== p2.rgb) $display("FAIL oor_frame (%0d,%0d): got %h want %h", p2.h, p2.v, {R, G, B}, p2.rgb);
                else n_pass++;
            end
        end
    endtask

    task automatic test_midframe_reset();
        run_to(0, 2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 3'd0, 3'd2, 2'd1);
            n_checks++;
            if ({vga_hsync, vga_vsync, frame_start, wr_ready, R, G, B} !== 28'h0)
                $display("FAIL midreset_outputs: got %h want 0", {vga_hsync, vga_vsync, frame_start, wr_ready, R, G, B});
            else n_pass++;
        end
        idle();
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL midreset_fs_early: got %b want 0", frame_start);
        else n_pass++;
        idle();
        n_checks++;
        if (frame_start !== 1'b1) $display("FAIL midreset_fs: got %b want 1", frame_start);
        else n_pass++;
        n_checks++;
        if ({R, G, B} !== ORIGIN_RGB) $display("FAIL midreset_origin: got %h want %h", {R, G, B}, ORIGIN_RGB);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3 * HT * VT; n++) begin
            tick(1'b1, 1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)), 2'($urandom_range(3)));
            n_checks++;
            if ({vga_hsync, vga_vsync, frame_start} !== {p2.hs, p2.vs, p2.fs})
                $display("FAIL rand_sync (%0d,%0d): got %b want %b", p2.h, p2.v, {vga_hsync, vga_vsync, frame_start}, {p2.hs, p2.vs, p2.fs});
            else n_pass++;
            n_checks++;
            if (wr_ready !== exp_ready) $display("FAIL rand_ready: got %b want %b", wr_ready, exp_ready);
            else n_pass++;
            if (p2.known) begin
                n_checks++;
                if ({R, G, B} !== p2.rgb) $display("FAIL rand_rgb (%0d,%0d): got %h want %h", p2.h, p2.v, {R, G, B}, p2.rgb);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; wr_valid = 1'b0; wr_channel = 3'd0; wr_index = 3'd0; wr_data = 2'd0;
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 8; i++)
                mem_m[c][i] = -1;
        p1 = blank_px();
        p2 = blank_px();
        test_reset();
        test_timing();
        init_buffers();
        test_handshake();
        test_trace();
        test_priority();
        test_out_of_range();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
